cpu_step_sequencer: RTL and testbench
=====================================

# cpu_step_sequencer

Consumer end of the CPU clock: samples `clock8bit` from the clock timer in the 100 MHz `clk` domain and turns its edges into single-cycle enables. It also runs the microinstruction step counter (T0..T(STEPS-1)) and drives `hlt` back to the clock timer when the HLT opcode executes. All CPU-side registers use `tick_rise`/`tick_fall` as clock enables instead of clocking on `clock8bit` directly.

## Interface
- `STEPS`, 5: number of microsteps per instruction (2..8).
- `HLT_OPCODE`, 4'hF: opcode that halts the CPU.
- `HLT_STEP`, 2: step at which the halt takes effect.
- `clk`  in  1  100 MHz system clock; the block's only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `clock8bit`  in  1  CPU clock from the clock timer; asynchronous to `clk`, slow (≥ 4 `clk` periods per level).
- `opcode`  in  4  instruction-register opcode field.
- `step_done`  in  1  control word "end of instruction": early wrap of the step counter.
- `tick_rise`  out  1  one-`clk` pulse per detected rising edge of `clock8bit`.
- `tick_fall`  out  1  one-`clk` pulse per detected falling edge of `clock8bit`.
- `step`  out  3  current microstep, 0..STEPS-1.
- `hlt`  out  1  halt request to the clock timer; level, sticky.
- `cycle_count`  out  16  rising ticks since reset, saturating.

## Operation
- Synchronizer: two flops `s1`, `s2` on `clock8bit`, plus history flop `prev` <= `s2`.
  - rise = `s2 & ~prev`.
  - fall = `~s2 & prev`.
  - rise and fall are mutually exclusive by construction.
- Two states: RUN and HALTED. Reset enters RUN.
- RUN, on rise:
  - `tick_rise` <= 1.
  - `cycle_count` increments and saturates at 16'hFFFF.
  - If `step == HLT_STEP` and `opcode == HLT_OPCODE`: go to HALTED, `hlt` <= 1, `step` holds.
  - Else if `step_done` or `step == STEPS-1`: `step` <= 0.
  - Else: `step` <= `step + 1`.
- RUN, on fall: `tick_fall` <= 1. Step and state are unchanged.
- HALTED:
  - `tick_rise` and `tick_fall` are held 0, including the fall caused by the clock timer gating `clock8bit` low.
  - `step` and `cycle_count` are frozen.
  - `hlt` stays 1.
  - Only `rst` exits.
- Priority within a rise: halt > `step_done` > natural wrap > increment.
- `opcode` and `step_done` are sampled only in the cycle a rise is detected. They must be stable there: the CPU updates them only on `tick_fall`.

## Timing
- Reset values: `s1`, `s2`, `prev` = 0; state RUN; `step` = 0; `hlt` = 0; `tick_rise` = `tick_fall` = 0; `cycle_count` = 0.
- Latency: if `clock8bit` is first sampled high at `clk` edge k, `s2` is high after k+1 and `tick_rise` is high for exactly the cycle after edge k+2. `step`, `cycle_count` and `hlt` update on that same edge k+2. Falls have the same 3-edge latency.
- All outputs are registered; there is no combinational path from input to output.
- `hlt` goes high at edge k+2 of the halting rise. The clock timer then forces `clock8bit` low.
- Reset mid-operation clears everything in one cycle. If `clock8bit` is high when `rst` drops, one rise is detected 2 cycles later and is counted normally. This is required behaviour, not suppressed.
- `clock8bit` pulses shorter than 2 `clk` periods may be missed. This is legal only because the clock-timer source is ≥ 1 Hz-scale.

## Structure
- Shared `cpu_pkg` holds:
  - `STEP_W` = 3.
  - Default `HLT_OPCODE`.
  - The state enum `seq_state_t` {RUN, HALTED}.
- One sub-module, `sync_edge_detect`: `clk`, `rst`, async input in; registered `rise`/`fall` pulses out. It contains `s1`/`s2`/`prev` and the output registers. It is reused for the manual-pulse button path.
- Top level holds the FSM, step counter and saturating counter.

## Test plan
- Reset then 3 `clock8bit` rises, `opcode` = 0, `step_done` = 0 -> exactly 3 `tick_rise` pulses, each 1 cycle wide and 3 `clk` edges after the input edge; `step` = 3, `cycle_count` = 3.
- 5 rises with STEPS = 5 -> `step` goes 1, 2, 3, 4, 0; one `tick_fall` per low phase.
- `step_done` = 1 at the rise while `step` = 2, opcode ≠ HLT -> `step` = 0 on the next tick, not 3.
- `opcode` = 4'hF at the rise while `step` = 2 -> `hlt` = 1 on that edge and `step` stays 2. Further `clock8bit` toggles produce no ticks and no count change. `rst` returns `hlt` = 0 and `step` = 0.
- Preload via 65,540 rises -> `cycle_count` holds at 16'hFFFF with no wrap.
- Assert `rst` for 1 cycle while `clock8bit` is high mid-instruction (`step` = 3) -> all outputs 0 the next cycle; one rise is detected 2 cycles after release; `step` = 1 and `cycle_count` = 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU control-path types and constants.
// No ports: step width, default halt opcode, sequencer state enum.
package cpu_pkg;

  localparam int STEP_W = 3;

  localparam logic [3:0] HLT_OPCODE_DFLT = 4'hF;

  typedef enum logic {
    RUN,
    HALTED
  } seq_state_t;

endpackage

// File: rtl/cpu_step_sequencer_if.sv
// CPU clock consumer bundle: clock8bit/opcode/step_done in,
// tick_rise/tick_fall/step/hlt/cycle_count out of the sequencer.
interface cpu_step_sequencer_if;
  import cpu_pkg::*;

  logic              clock8bit;
  logic [3:0]        opcode;
  logic              step_done;
  logic              tick_rise;
  logic              tick_fall;
  logic [STEP_W-1:0] step;
  logic              hlt;
  logic [15:0]       cycle_count;

  modport master (
    output clock8bit,
    output opcode,
    output step_done,
    input  tick_rise,
    input  tick_fall,
    input  step,
    input  hlt,
    input  cycle_count
  );

  modport slave (
    input  clock8bit,
    input  opcode,
    input  step_done,
    output tick_rise,
    output tick_fall,
    output step,
    output hlt,
    output cycle_count
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer + edge detector for a slow async level.
// Ports: clk, rst, din, en in; rise_now (comb), rise, fall out.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic rise_now,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
      rise <= en & s2 & ~prev;
      fall <= en & ~s2 & prev;
    end
  end

  // Same-cycle detect so the owner can update state on the
  // edge that also launches the registered pulse.
  assign rise_now = s2 & ~prev;

endmodule

// File: rtl/cpu_step_sequencer.sv
// Turns clock8bit edges into clk-domain ticks; runs step counter.
// Ports: clk, rst, bus (slave): clock8bit/opcode/step_done -> ticks.
module cpu_step_sequencer
  import cpu_pkg::*;
#(
  parameter int         STEPS      = 5,
  parameter logic [3:0] HLT_OPCODE = HLT_OPCODE_DFLT,
  parameter int         HLT_STEP   = 2
) (
  input logic           clk,
  input logic           rst,
  cpu_step_sequencer_if.slave bus
);

  localparam logic [STEP_W-1:0] LAST  = STEP_W'(STEPS - 1);
  localparam logic [STEP_W-1:0] HSTEP = STEP_W'(HLT_STEP);
  localparam logic [STEP_W-1:0] ONE   = STEP_W'(1);

  seq_state_t        state_q;
  seq_state_t        state_n;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_n;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_n;
  logic              hlt_q;
  logic              hlt_n;
  logic              rise_now;
  logic              run;

  assign run = (state_q == RUN);

  // Ticks are suppressed while halted, which also hides the
  // fall produced when the timer gates clock8bit low.
  sync_edge_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .din      (bus.clock8bit),
    .en       (run),
    .rise_now (rise_now),
    .rise     (bus.tick_rise),
    .fall     (bus.tick_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      step_q  <= '0;
      cnt_q   <= '0;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      step_q  <= step_n;
      cnt_q   <= cnt_n;
      hlt_q   <= hlt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    step_n  = step_q;
    cnt_n   = cnt_q;
    hlt_n   = hlt_q;
    if (run && rise_now) begin
      if (cnt_q != 16'hFFFF) cnt_n = cnt_q + 16'd1;
      // Halt outranks step_done, which outranks the wrap.
      priority case (1'b1)
        (step_q == HSTEP && bus.opcode == HLT_OPCODE): begin
          state_n = HALTED;
          hlt_n   = 1'b1;
        end
        (bus.step_done || step_q == LAST): step_n = '0;
        default: step_n = step_q + ONE;
      endcase
    end
  end

  assign bus.step        = step_q;
  assign bus.cycle_count = cnt_q;
  assign bus.hlt         = hlt_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Self-checking bench for cpu_step_sequencer.
// Reference model tracks step/count/halt per clock8bit rise.
module tb_cpu_step_sequencer;

  localparam int         STEPS    = 5;
  localparam logic [3:0] HLT_OP   = 4'hF;
  localparam int         HLT_STEP = 2;

  logic clk = 1'b0;
  logic rst;

  cpu_step_sequencer_if bus ();

  cpu_step_sequencer #(
    .STEPS      (STEPS),
    .HLT_OPCODE (HLT_OP),
    .HLT_STEP   (HLT_STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int          m_step;
  logic [15:0] m_cnt;
  bit          m_halt;
  bit          m_tick;

  int obs_rn, obs_ra, obs_fn, obs_fa;
  logic [2:0] obs_pre;

  task automatic model_reset();
    m_step = 0;
    m_cnt  = 16'h0;
    m_halt = 1'b0;
  endtask

  task automatic model_rise();
    m_tick = !m_halt;
    if (!m_halt) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_step == HLT_STEP && bus.opcode == HLT_OP) m_halt = 1'b1;
      else if (bus.step_done) m_step = 0;
      else m_step = (m_step + 1) % STEPS;
    end
  endtask

  // Called #1 after a posedge; edge i=0 is the first sample.
  task automatic drive_level(input logic lvl, input int len);
    bus.clock8bit = lvl;
    obs_rn = 0; obs_ra = -1; obs_fn = 0; obs_fa = -1;
    obs_pre = bus.step;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      if (bus.tick_rise) begin
        obs_rn++;
        if (obs_ra < 0) obs_ra = i;
      end
      if (bus.tick_fall) begin
        obs_fn++;
        if (obs_fa < 0) obs_fa = i;
      end
      if (i == 1) obs_pre = bus.step;
    end
  endtask

  task automatic do_reset();
    bus.clock8bit = 1'b0;
    bus.opcode    = 4'h0;
    bus.step_done = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({bus.tick_rise, bus.tick_fall, bus.hlt} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000",
               {bus.tick_rise, bus.tick_fall, bus.hlt});
    end
    n_vec++;
    if (bus.step !== 3'd0 || bus.cycle_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_regs: got step %0d cnt %0d want 0 0",
               bus.step, bus.cycle_count);
    end
  endtask

  task automatic test_three_rises();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      drive_level(1'b1, 5);
      model_rise();
      n_vec++;
      if (obs_rn !== 1 || obs_ra !== 2) begin
        n_bad++;
        $display("FAIL three_tick%0d: got n=%0d at=%0d want n=1 at=2",
                 r, obs_rn, obs_ra);
      end
      drive_level(1'b0, 5);
    end
    n_vec++;
    if (bus.step !== 3'd3 || bus.cycle_count !== 16'd3) begin
      n_bad++;
      $display("FAIL three_final: got step %0d cnt %0d want 3 3",
               bus.step, bus.cycle_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      drive_level(1'b1, 5);
      model_rise();
      n_vec++;
      if (bus.step !== 3'(m_step)) begin
        n_bad++;
        $display("FAIL wrap_step%0d: got %0d want %0d",
                 r, bus.step, m_step);
      end
      drive_level(1'b0, 5);
      n_vec++;
      if (obs_fn !== 1 || obs_fa !== 2) begin
        n_bad++;
        $display("FAIL wrap_fall%0d: got n=%0d at=%0d want n=1 at=2",
                 r, obs_fn, obs_fa);
      end
    end
    n_vec++;
    if (bus.step !== 3'd0) begin
      n_bad++;
      $display("FAIL wrap_zero: got %0d want 0", bus.step);
    end
  endtask

  task automatic test_step_done();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      drive_level(1'b1, 5);
      model_rise();
      drive_level(1'b0, 5);
    end
    bus.step_done = 1'b1;
    drive_level(1'b1, 5);
    model_rise();
    n_vec++;
    if (bus.step !== 3'd0 || m_step != 0) begin
      n_bad++;
      $display("FAIL step_done: got %0d want 0", bus.step);
    end
    bus.step_done = 1'b0;
    drive_level(1'b0, 5);
    drive_level(1'b1, 5);
    model_rise();
    n_vec++;
    if (bus.step !== 3'(m_step)) begin
      n_bad++;
      $display("FAIL step_done_next: got %0d want %0d",
               bus.step, m_step);
    end
  endtask

  task automatic test_halt();
    logic [15:0] held;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      drive_level(1'b1, 5);
      model_rise();
      drive_level(1'b0, 5);
    end
    bus.opcode = HLT_OP;
    drive_level(1'b1, 5);
    model_rise();
    n_vec++;
    if (obs_rn !== 1 || bus.hlt !== 1'b1 || bus.step !== 3'd2) begin
      n_bad++;
      $display("FAIL halt_enter: got n=%0d hlt=%b step=%0d want 1 1 2",
               obs_rn, bus.hlt, bus.step);
    end
    held = bus.cycle_count;
    n_vec++;
    if (held !== m_cnt) begin
      n_bad++;
      $display("FAIL halt_cnt: got %0d want %0d", held, m_cnt);
    end
    drive_level(1'b0, 6);
    n_vec++;
    if (obs_fn !== 0) begin
      n_bad++;
      $display("FAIL halt_gate_fall: got %0d ticks want 0", obs_fn);
    end
    for (int r = 0; r < 2; r++) begin
      drive_level(1'b1, 5);
      drive_level(1'b0, 5);
    end
    n_vec++;
    if (bus.cycle_count !== m_cnt || bus.step !== 3'd2 ||
        bus.hlt !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_frozen: got cnt %0d step %0d hlt %b",
               bus.cycle_count, bus.step, bus.hlt);
    end
    do_reset();
    n_vec++;
    if (bus.hlt !== 1'b0 || bus.step !== 3'd0) begin
      n_bad++;
      $display("FAIL halt_exit: got hlt %b step %0d want 0 0",
               bus.hlt, bus.step);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    force dut.cnt_q = 16'hFFFC;
    #1;
    release dut.cnt_q;
    m_cnt = 16'hFFFC;
    for (int r = 0; r < 6; r++) begin
      drive_level(1'b1, 4);
      model_rise();
      n_vec++;
      if (bus.cycle_count !== m_cnt) begin
        n_bad++;
        $display("FAIL sat_cnt%0d: got %h want %h",
                 r, bus.cycle_count, m_cnt);
      end
      drive_level(1'b0, 4);
    end
    n_vec++;
    if (bus.cycle_count !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_hold: got %h want ffff", bus.cycle_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      if (r != 0) drive_level(1'b0, 5);
      drive_level(1'b1, 5);
      model_rise();
    end
    n_vec++;
    if (bus.step !== 3'd3) begin
      n_bad++;
      $display("FAIL mid_pre: got step %0d want 3", bus.step);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({bus.tick_rise, bus.tick_fall, bus.hlt,
         bus.step, bus.cycle_count} !== 22'd0) begin
      n_bad++;
      $display("FAIL mid_clear: got step %0d cnt %0d hlt %b",
               bus.step, bus.cycle_count, bus.hlt);
    end
    rst = 1'b0;
    model_reset();
    drive_level(1'b1, 5);
    model_rise();
    n_vec++;
    if (obs_rn !== 1 || obs_ra !== 2) begin
      n_bad++;
      $display("FAIL mid_rise: got n=%0d at=%0d want n=1 at=2",
               obs_rn, obs_ra);
    end
    n_vec++;
    if (bus.step !== 3'd1 || bus.cycle_count !== 16'd1) begin
      n_bad++;
      $display("FAIL mid_after: got step %0d cnt %0d want 1 1",
               bus.step, bus.cycle_count);
    end
    drive_level(1'b0, 5);
  endtask

  task automatic test_random();
    bit cur_lvl;
    bit exp_fall;
    int pre_step;
    do_reset();
    cur_lvl = 1'b0;
    for (int r = 0; r < 60; r++) begin
      if (m_halt && $urandom_range(0, 1) == 1) begin
        do_reset();
        cur_lvl = 1'b0;
      end
      exp_fall = cur_lvl && !m_halt;
      bus.opcode    = ($urandom_range(0, 5) == 0) ? HLT_OP
                                                  : 4'($urandom_range(0, 14));
      bus.step_done = ($urandom_range(0, 3) == 0);
      drive_level(1'b0, $urandom_range(4, 7));
      cur_lvl = 1'b0;
      n_vec++;
      if (obs_fn !== int'(exp_fall) || (exp_fall && obs_fa !== 2)) begin
        n_bad++;
        $display("FAIL rnd_fall%0d: got n=%0d at=%0d want n=%0d",
                 r, obs_fn, obs_fa, exp_fall);
      end
      pre_step = m_step;
      drive_level(1'b1, $urandom_range(4, 7));
      cur_lvl = 1'b1;
      model_rise();
      n_vec++;
      if (obs_rn !== int'(m_tick) || (m_tick && obs_ra !== 2)) begin
        n_bad++;
        $display("FAIL rnd_rise%0d: got n=%0d at=%0d want n=%0d",
                 r, obs_rn, obs_ra, m_tick);
      end
      n_vec++;
      if (obs_pre !== 3'(pre_step)) begin
        n_bad++;
        $display("FAIL rnd_early%0d: got %0d want %0d",
                 r, obs_pre, pre_step);
      end
      n_vec++;
      if (bus.step !== 3'(m_step) || bus.cycle_count !== m_cnt ||
          bus.hlt !== m_halt) begin
        n_bad++;
        $display("FAIL rnd_state%0d: got %0d/%0d/%b want %0d/%0d/%b",
                 r, bus.step, bus.cycle_count, bus.hlt,
                 m_step, m_cnt, m_halt);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.clock8bit = 1'b0;
    bus.opcode    = 4'h0;
    bus.step_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_three_rises();
    test_wrap();
    test_step_done();
    test_halt();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end want finish");
    $fatal(1, "timeout");
  end

endmodule
